fetch_stall_controller: RTL and testbench
=========================================

FETCH_STALL_CONTROLLER -- requirements
Module: fetch_stall_controller

Interface
REQ-001 The block SHALL have one parameter: REFILL_TIMEOUT, default 255, the maximum number of cycles a refill may remain outstanding (range 2..255).
REQ-002 The block SHALL have the following ports, one per line below:
  clock  in  1  single clock, all state updates on rising edge.
  reset_n  in  1  asynchronous, active-low reset.
  fetch_valid  in  1  the IF stage presents a fetch this cycle.
  hit  in  1  I-cache hit for the current fetch address.
  load_use_hazard  in  1  ID-stage hazard stall request.
  branch_taken  in  1  EX-stage redirect; the PC target is valid this cycle only.
  mem_ack  in  1  memory accepted the refill request.
  mem_done  in  1  refill line written into the I-cache, one-cycle pulse.
  mem_req  out  1  refill request, level, held until acknowledged.
  pc_write  out  1  PC register load enable.
  if_id_write  out  1  IF/ID pipeline register load enable.
  if_id_flush  out  1  IF/ID register clear to NOP.
  refill_error  out  1  sticky refill-timeout flag.
  stall_cycles  out  32  stall-cycle count (FETCH_PERF_CNT_EN only).
  miss_count  out  16  I-cache miss count (FETCH_PERF_CNT_EN only).
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-low.

Function
REQ-004 The state machine SHALL have five states: RUN, MISS_REQ, MISS_WAIT, REFILL and ERROR.
REQ-005 In RUN with branch_taken=1:
  - pc_write=1, if_id_write=0, if_id_flush=1.
  - stay in RUN.
  - hit and load_use_hazard are ignored, because the fetch is on the wrong path.
REQ-006 In RUN with branch_taken=0, fetch_valid=1 and hit=0:
  - pc_write=0, if_id_write=0.
  - next state MISS_REQ.
  - miss_count increments.
REQ-007 In RUN otherwise: pc_write = if_id_write = !load_use_hazard, if_id_flush=0.
REQ-008 In MISS_REQ: mem_req=1 until a cycle with mem_ack=1, then the next state is MISS_WAIT.
REQ-009 In MISS_WAIT: mem_req=0; mem_done=1 moves the state to REFILL.
REQ-010 REFILL SHALL last exactly one cycle with pc_write=0 and if_id_write=0, then return to RUN, where the fetch is re-evaluated and hits.
REQ-011 In MISS_REQ, MISS_WAIT and REFILL, pc_write=0 and if_id_write=0, except when branch_taken=1:
  - pc_write=1 and if_id_flush=1 in that cycle.
  - the outstanding refill is not aborted; the state sequence continues unchanged.
REQ-012 An 8-bit timeout counter SHALL:
  - clear on entry to MISS_REQ.
  - increment each cycle in MISS_REQ or MISS_WAIT.
  - on reaching REFILL_TIMEOUT without the required mem_ack/mem_done, cause the next state to be ERROR.
REQ-013 mem_done and mem_ack arriving in the timeout cycle SHALL take priority over the timeout.
REQ-014 In ERROR:
  - refill_error=1, pc_write=0, if_id_write=0, if_id_flush=0, mem_req=0.
  - all inputs are ignored, including branch_taken.
  - the state is left only by reset.
REQ-015 mem_ack or mem_done arriving in any state where it is not expected SHALL be ignored.
REQ-016 All outputs except the counters SHALL be decoded combinationally from the current state and the inputs; there are no registered output delays.
REQ-017 Miss-to-resume latency: with mem_ack in the first MISS_REQ cycle and mem_done k cycles later, the stall lasts 3+k cycles.

Reset
REQ-018 While reset_n=0:
  - state=RUN.
  - timeout counter=0, refill_error=0, mem_req=0.
  - stall_cycles=0 and miss_count=0.
REQ-019 Asserting reset mid-refill SHALL abandon the refill with no further mem_req; after release the block is in RUN.
REQ-020 During reset, pc_write and if_id_write SHALL be 0, and if_id_flush SHALL be 1.

Configuration
REQ-021 With FETCH_PERF_CNT_EN defined:
  - stall_cycles counts every cycle with pc_write=0 out of reset.
  - miss_count counts RUN-to-MISS_REQ transitions.
  - both counters saturate at all-ones.
REQ-022 Without FETCH_PERF_CNT_EN, the ports stall_cycles and miss_count and their counter logic SHALL be absent; all other behaviour is identical.

Verification
REQ-023 Hit stream: fetch_valid=1, hit=1 for 10 cycles -> pc_write=1 and if_id_write=1 every cycle, mem_req never asserted.
REQ-024 Miss: hit=0 at cycle 0, mem_ack at cycle 1, mem_done at cycle 4 -> mem_req high only at cycle 1, pc_write low for cycles 0..5, high at cycle 6 with hit=1, miss_count=1, stall_cycles=6.
REQ-025 Branch during miss: branch_taken=1 in MISS_WAIT -> pc_write=1 and if_id_flush=1 that cycle only, the refill still completes, the state returns to RUN.
REQ-026 Simultaneous events in RUN:
  - branch_taken=1 with hit=0 -> if_id_flush=1, no transition to MISS_REQ, miss_count unchanged.
  - load_use_hazard=1 with hit=1 -> pc_write=0, if_id_write=0.
REQ-027 Timeout: REFILL_TIMEOUT=4, mem_ack never asserted -> ERROR after 4 cycles in MISS_REQ, refill_error=1 sticky, pc_write=0 even with branch_taken=1.
REQ-028 Reset: reset_n low mid-MISS_WAIT -> mem_req=0 and refill_error=0 at once; after release with hit=1 -> pc_write=1.

Source files
------------

// File: rtl/fetch_stall_controller.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stall_controller
// Description : IF-stage stall/flush controller with I-cache refill handshake
//               and refill timeout. Optional perf counters: FETCH_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stall_controller #(
  parameter int unsigned REFILL_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        fetch_valid,
  input  logic        hit,
  input  logic        load_use_hazard,
  input  logic        branch_taken,
  input  logic        mem_ack,
  input  logic        mem_done,
  output logic        mem_req,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        refill_error
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [15:0] miss_count
`endif
);

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_MISS_REQ  = 3'd1,
    ST_MISS_WAIT = 3'd2,
    ST_REFILL    = 3'd3,
    ST_ERROR     = 3'd4
  } state_t;

  // The counter reads N-1 during the N-th outstanding cycle.
  localparam logic [7:0] C_TIMEOUT_LAST = 8'(REFILL_TIMEOUT - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_tmo_cnt;
  logic       w_timeout;
  logic       w_enter_miss;
  logic       w_pc_write;
  logic       w_if_id_write;
  logic       w_if_id_flush;
  logic       w_mem_req;

  assign w_timeout = (r_tmo_cnt >= C_TIMEOUT_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tmo_cnt <= 8'd0;
    end else if (w_enter_miss) begin
      r_tmo_cnt <= 8'd0;
    end else if (r_state == ST_MISS_REQ || r_state == ST_MISS_WAIT) begin
      r_tmo_cnt <= r_tmo_cnt + 8'd1;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_enter_miss  = 1'b0;
    w_pc_write    = 1'b0;
    w_if_id_write = 1'b0;
    w_if_id_flush = 1'b0;
    w_mem_req     = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (branch_taken) begin
          w_pc_write    = 1'b1;
          w_if_id_flush = 1'b1;
        end else if (fetch_valid && !hit) begin
          w_state_nxt  = ST_MISS_REQ;
          w_enter_miss = 1'b1;
        end else begin
          w_pc_write    = !load_use_hazard;
          w_if_id_write = !load_use_hazard;
        end
      end
      ST_MISS_REQ: begin
        w_mem_req     = 1'b1;
        w_pc_write    = branch_taken;
        w_if_id_flush = branch_taken;
        if (mem_ack) begin
          w_state_nxt = ST_MISS_WAIT;
        end else if (w_timeout) begin
          w_state_nxt = ST_ERROR;
        end
      end
      ST_MISS_WAIT: begin
        w_pc_write    = branch_taken;
        w_if_id_flush = branch_taken;
        if (mem_done) begin
          w_state_nxt = ST_REFILL;
        end else if (w_timeout) begin
          w_state_nxt = ST_ERROR;
        end
      end
      ST_REFILL: begin
        // A redirect here must not cancel the refill; the line is already in.
        w_pc_write    = branch_taken;
        w_if_id_flush = branch_taken;
        w_state_nxt   = ST_RUN;
      end
      ST_ERROR: begin
        w_state_nxt = ST_ERROR;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // Reset overrides the decode so the pipeline is held and flushed meanwhile.
  assign pc_write     = reset_n & w_pc_write;
  assign if_id_write  = reset_n & w_if_id_write;
  assign if_id_flush  = !reset_n | w_if_id_flush;
  assign mem_req      = reset_n & w_mem_req;
  assign refill_error = reset_n & (r_state == ST_ERROR);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [15:0] r_miss_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cycles <= 32'd0;
      r_miss_count   <= 16'd0;
    end else begin
      if (!w_pc_write && !(&r_stall_cycles)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (w_enter_miss && !(&r_miss_count)) begin
        r_miss_count <= r_miss_count + 16'd1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign miss_count   = r_miss_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stall_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stall_controller
// Description : Scoreboard bench for fetch_stall_controller (REFILL_TIMEOUT=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stall_controller;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        fetch_valid = 1'b0;
  logic        hit = 1'b0;
  logic        load_use_hazard = 1'b0;
  logic        branch_taken = 1'b0;
  logic        mem_ack = 1'b0;
  logic        mem_done = 1'b0;
  logic        mem_req;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        refill_error;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [15:0] miss_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      tag;
    logic [4:0] exp;
  } exp_t;

  exp_t sb[$];

  fetch_stall_controller #(.REFILL_TIMEOUT(4)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .fetch_valid     (fetch_valid),
    .hit             (hit),
    .load_use_hazard (load_use_hazard),
    .branch_taken    (branch_taken),
    .mem_ack         (mem_ack),
    .mem_done        (mem_done),
    .mem_req         (mem_req),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .refill_error    (refill_error)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cycles    (stall_cycles),
    .miss_count      (miss_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // in  = {fetch_valid, hit, load_use_hazard, branch_taken, mem_ack, mem_done}
  // exp = {pc_write, if_id_write, if_id_flush, mem_req, refill_error}
  task automatic step(input string tag, input logic [5:0] in, input logic [4:0] exp);
    exp_t e;
    {fetch_valid, hit, load_use_hazard, branch_taken, mem_ack, mem_done} = in;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
    #3;
    e = sb.pop_front();
    check_val(e.tag, {27'd0, pc_write, if_id_write, if_id_flush, mem_req, refill_error},
              {27'd0, e.exp});
    @(negedge clock);
  endtask

  initial begin
    @(negedge clock);
    step("reset_hold", 6'b110000, 5'b00100);
`ifdef FETCH_PERF_CNT_EN
    check_val("rst_stall_cnt", stall_cycles, 32'd0);
    check_val("rst_miss_cnt", {16'd0, miss_count}, 32'd0);
`endif
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) step("hit_stream", 6'b110000, 5'b11000);

    // Miss with ack at 1, done at 4 (done lands in the timeout cycle)
    step("miss_c0", 6'b100000, 5'b00000);
    step("miss_c1_req", 6'b100010, 5'b00010);
    step("miss_c2_wait", 6'b100000, 5'b00000);
    step("miss_c3_wait", 6'b100000, 5'b00000);
    step("miss_c4_done", 6'b100001, 5'b00000);
    step("miss_c5_refill", 6'b100000, 5'b00000);
    step("miss_c6_resume", 6'b110000, 5'b11000);
`ifdef FETCH_PERF_CNT_EN
    check_val("miss_count_1", {16'd0, miss_count}, 32'd1);
    check_val("stall_cycles_6", stall_cycles, 32'd6);
`endif

    // Branch in MISS_WAIT; stray mem_done in MISS_REQ ignored
    step("bm_c0", 6'b100000, 5'b00000);
    step("bm_stray_done", 6'b100001, 5'b00010);
    step("bm_ack", 6'b100010, 5'b00010);
    step("bm_wait_branch", 6'b100100, 5'b10100);
    step("bm_done", 6'b100001, 5'b00000);
    step("bm_refill", 6'b100000, 5'b00000);
    step("bm_resume", 6'b110000, 5'b11000);

    // Simultaneous events in RUN
    step("br_with_miss", 6'b100100, 5'b10100);
    step("after_br_run", 6'b110000, 5'b11000);
    step("luh_with_hit", 6'b111000, 5'b00000);
    step("after_luh", 6'b110000, 5'b11000);
    step("idle_no_fetch", 6'b000000, 5'b11000);
`ifdef FETCH_PERF_CNT_EN
    check_val("miss_count_2", {16'd0, miss_count}, 32'd2);
    check_val("stall_cycles_12", stall_cycles, 32'd12);
`endif

    // Reset mid-MISS_WAIT
    step("rm_c0", 6'b100000, 5'b00000);
    step("rm_ack", 6'b100010, 5'b00010);
    step("rm_wait", 6'b100000, 5'b00000);
    reset_n = 1'b0;
    step("rm_in_reset", 6'b100000, 5'b00100);
    step("rm_reset_ack", 6'b100010, 5'b00100);
`ifdef FETCH_PERF_CNT_EN
    check_val("rm_miss_cnt_clr", {16'd0, miss_count}, 32'd0);
    check_val("rm_stall_cnt_clr", stall_cycles, 32'd0);
`endif
    reset_n = 1'b1;
    step("rm_release_hit", 6'b110000, 5'b11000);

    // Timeout: no ack for 4 MISS_REQ cycles
    step("to_c0", 6'b100000, 5'b00000);
    for (int i = 0; i < 4; i++) step("to_req", 6'b100000, 5'b00010);
    step("to_err_branch", 6'b100100, 5'b00001);
    step("to_err_ackdone", 6'b100011, 5'b00001);
    step("to_err_hit", 6'b110000, 5'b00001);
    step("to_err_sticky", 6'b000000, 5'b00001);
    reset_n = 1'b0;
    step("to_reset", 6'b110000, 5'b00100);
    reset_n = 1'b1;
    step("to_release_hit", 6'b110000, 5'b11000);

    check_val("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
